traffic_sensor_model: RTL

Vehicle-side model of the two-street intersection, driven by the light codes from the intersection controller. Tracks per-street queues of waiting cars from arrival pulses and drains one car every DEPART_CYCLES while that street is green. Drives the occupancy sensors T_A/T_B back to the controller, closing the loop for system simulation and FPGA demo. Also monitors the light codes for illegal combinations.

---
 rtl/traffic_sensor_model.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/traffic_sensor_model.sv
// Vehicle-side intersection model: per-street car queues drained on green,
// occupancy sensors T_A/T_B back to the controller, and a light-code monitor.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   arrive_A, arrive_B    one car joins the street queue per cycle high
//   L_A, L_B              light codes: 00 green, 01 yellow, 11 red, 10 illegal
//   T_A, T_B              street occupied (queue count non-zero)
//   count_A, count_B      cars waiting per street
//   depart_A, depart_B    registered one-cycle pulse: a car left the street
//   overflow_A/B          sticky: an arrival was dropped at full queue
//   conflict              sticky: both lights non-red in one cycle
//   bad_code              sticky: code 10 seen on either light

module traffic_sensor_street #(
    parameter int QUEUE_W       = 4,
    parameter int DEPART_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arrive,
    input  logic [1:0]         light,
    output logic [QUEUE_W-1:0] count,
    output logic               depart,
    output logic               overflow
);

    localparam int TW = $clog2(DEPART_CYCLES) + 1;
    localparam logic [TW-1:0]      LAST = TW'(DEPART_CYCLES - 1);
    localparam logic [QUEUE_W-1:0] FULL = {QUEUE_W{1'b1}};

    typedef enum logic {
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t              state;
    logic [TW-1:0]       timer;
    logic                green;
    logic                fire;
    logic                accept;
    logic [QUEUE_W-1:0]  count_nxt;

    always_comb begin
        green     = (light == 2'b00);
        fire      = 1'b0;
        accept    = 1'b0;
        count_nxt = count;
        fire = (state == S_DRAIN) && green && (timer == LAST)
               && (count != '0);
        // A departure in the same cycle frees the slot a full queue needs.
        accept = arrive && ((count != FULL) || fire);
        count_nxt = count + QUEUE_W'(accept) - QUEUE_W'(fire);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_WAIT;
            timer    <= '0;
            count    <= '0;
            depart   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count  <= count_nxt;
            depart <= fire;
            if (arrive && !accept)
                overflow <= 1'b1;
            unique case (state)
                S_WAIT: begin
                    timer <= '0;
                    if (green && (count != '0))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!green) begin
                        // Any non-green cycle abandons the partial departure.
                        timer <= '0;
                        state <= S_WAIT;
                    end else if (fire) begin
                        timer <= '0;
                        if (count_nxt == '0)
                            state <= S_WAIT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule

module traffic_sensor_model #(
    parameter int QUEUE_W       = 4,
    parameter int DEPART_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arrive_A,
    input  logic               arrive_B,
    input  logic [1:0]         L_A,
    input  logic [1:0]         L_B,
    output logic               T_A,
    output logic               T_B,
    output logic [QUEUE_W-1:0] count_A,
    output logic [QUEUE_W-1:0] count_B,
    output logic               depart_A,
    output logic               depart_B,
    output logic               overflow_A,
    output logic               overflow_B,
    output logic               conflict,
    output logic               bad_code
);

    traffic_sensor_street #(
        .QUEUE_W      (QUEUE_W),
        .DEPART_CYCLES(DEPART_CYCLES)
    ) u_street_a (
        .clk     (clk),
        .reset   (reset),
        .arrive  (arrive_A),
        .light   (L_A),
        .count   (count_A),
        .depart  (depart_A),
        .overflow(overflow_A)
    );

    traffic_sensor_street #(
        .QUEUE_W      (QUEUE_W),
        .DEPART_CYCLES(DEPART_CYCLES)
    ) u_street_b (
        .clk     (clk),
        .reset   (reset),
        .arrive  (arrive_B),
        .light   (L_B),
        .count   (count_B),
        .depart  (depart_B),
        .overflow(overflow_B)
    );

    // Occupancy comes straight off the count registers.
    assign T_A = (count_A != '0);
    assign T_B = (count_B != '0);

    // Illegal code 10 counts as non-red here, so it can also raise conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            if ((L_A != 2'b11) && (L_B != 2'b11))
                conflict <= 1'b1;
            if ((L_A == 2'b10) || (L_B == 2'b10))
                bad_code <= 1'b1;
        end
    end

endmodule
